regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: requester 0 is the ALU path and requester 1 is the load/multi-cycle path. It issues one registered write per cycle. It also keeps a busy scoreboard of destinations that have been reserved but not yet written, which decode uses to detect RAW/WAW hazards. It sits between the execute/memory stages and the `register` block, and drives `RegWrAddr`, `RegWrData` and `RegWrite`.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its writeback arbiter.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned ZERO_REG   = 0;

    // Identity of a writeback requester; also the encoding of the round-robin pointer.
    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per register, set by decode reservations and
// cleared when the matching write commits; register 0 is never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_valid_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_valid_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] chk_addr_a_i,
    input  logic [ADDR_W-1:0] chk_addr_b_i,
    output logic              chk_busy_a_c_o,
    output logic              chk_busy_b_c_o
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Set is applied after clear: a new reservation follows the retiring write.
    always_comb begin
        busy_d = busy_q;
        if (clr_valid_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_valid_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign chk_busy_a_c_o = busy_q[chk_addr_a_i];
    assign chk_busy_b_c_o = busy_q[chk_addr_b_i];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// and load writeback paths, with registered write outputs and a busy scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0Valid,
    input  logic [ADDR_W-1:0] Req0Addr,
    input  logic [DATA_W-1:0] Req0Data,
    output logic              Req0Ready,
    input  logic              Req1Valid,
    input  logic [ADDR_W-1:0] Req1Addr,
    input  logic [DATA_W-1:0] Req1Data,
    output logic              Req1Ready,
    input  logic              ResvValid,
    input  logic [ADDR_W-1:0] ResvAddr,
    input  logic [ADDR_W-1:0] ChkAddrA,
    input  logic [ADDR_W-1:0] ChkAddrB,
    output logic              ChkBusyA,
    output logic              ChkBusyB,
    output logic [ADDR_W-1:0] RegWrAddr,
    output logic [DATA_W-1:0] RegWrData,
    output logic              RegWrite
);

    req_id_e           last_q;
    req_id_e           last_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] wr_data_d;
    logic              wr_en_q;
    logic              wr_en_d;
    logic              gnt0_c;
    logic              gnt1_c;

    // Grant: a lone requester wins; under contention the one not served last wins.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!Reset) begin
            if (Req0Valid && Req1Valid) begin
                gnt0_c = (last_q == REQ_LOAD);
                gnt1_c = (last_q == REQ_ALU);
            end else begin
                gnt0_c = Req0Valid;
                gnt1_c = Req1Valid;
            end
        end
    end

    assign Req0Ready = gnt0_c;
    assign Req1Ready = gnt1_c;

    // Capture the granted request; writes to register 0 are accepted but suppressed.
    always_comb begin
        last_d    = last_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        if (gnt0_c) begin
            last_d    = REQ_ALU;
            wr_addr_d = Req0Addr;
            wr_data_d = Req0Data;
            wr_en_d   = (Req0Addr != ADDR_W'(ZERO_REG));
        end else if (gnt1_c) begin
            last_d    = REQ_LOAD;
            wr_addr_d = Req1Addr;
            wr_data_d = Req1Data;
            wr_en_d   = (Req1Addr != ADDR_W'(ZERO_REG));
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_q    <= REQ_LOAD;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            last_q    <= last_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign RegWrAddr = wr_addr_q;
    assign RegWrData = wr_data_q;
    assign RegWrite  = wr_en_q;

    // The committing write clears its busy bit at the same edge the register file latches it.
    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk_i          (Clk),
        .rst_i          (Reset),
        .set_valid_i    (ResvValid),
        .set_addr_i     (ResvAddr),
        .clr_valid_i    (wr_en_q),
        .clr_addr_i     (wr_addr_q),
        .chk_addr_a_i   (ChkAddrA),
        .chk_addr_b_i   (ChkAddrB),
        .chk_busy_a_c_o (ChkBusyA),
        .chk_busy_b_c_o (ChkBusyB)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios plus random traffic
// checked against a behavioural model of grants, writes and busy bits.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int unsigned AW = REG_ADDR_W;
    localparam int unsigned DW = REG_DATA_W;
    localparam int unsigned NR = NUM_REGS;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Req0Valid, Req1Valid, ResvValid;
    logic [AW-1:0] Req0Addr, Req1Addr, ResvAddr, ChkAddrA, ChkAddrB;
    logic [DW-1:0] Req0Data, Req1Data;
    logic          Req0Ready, Req1Ready, ChkBusyA, ChkBusyB, RegWrite;
    logic [AW-1:0] RegWrAddr;
    logic [DW-1:0] RegWrData;

    regfile_wb_arbiter dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req0Valid (Req0Valid),
        .Req0Addr  (Req0Addr),
        .Req0Data  (Req0Data),
        .Req0Ready (Req0Ready),
        .Req1Valid (Req1Valid),
        .Req1Addr  (Req1Addr),
        .Req1Data  (Req1Data),
        .Req1Ready (Req1Ready),
        .ResvValid (ResvValid),
        .ResvAddr  (ResvAddr),
        .ChkAddrA  (ChkAddrA),
        .ChkAddrB  (ChkAddrB),
        .ChkBusyA  (ChkBusyA),
        .ChkBusyB  (ChkBusyB),
        .RegWrAddr (RegWrAddr),
        .RegWrData (RegWrData),
        .RegWrite  (RegWrite)
    );

    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned   cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    bit            ref_busy [NR];
    int            last_winner;
    bit            ret_v;
    logic [AW-1:0] ret_a;
    bit            g0_o, g1_o;

    // Decode must never reserve a register that is busy and not retiring this cycle.
    a_no_waw: assert property (@(posedge Clk) disable iff (Reset)
        (ResvValid && ResvAddr != '0 && ChkAddrB == ResvAddr && ChkBusyB)
            |-> (RegWrite && RegWrAddr == ResvAddr))
        else $error("WAW reservation of busy register %0d", ResvAddr);

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (ref_busy[i]) ref_busy[i] = 1'b0;
        last_winner = 1;
        ret_v       = 1'b0;
        ret_a       = '0;
        exp_q.delete();
    endtask

    // One clock cycle of stimulus; checks combinational outputs and advances the model.
    task automatic drive_cycle(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input bit rv, input logic [AW-1:0] ra,
                               input logic [AW-1:0] ca, input logic [AW-1:0] cb);
        int            w;
        exp_t          e;
        logic [AW-1:0] ga;
        @(negedge Clk);
        Reset = 1'b0;
        Req0Valid = v0; Req0Addr = a0; Req0Data = d0;
        Req1Valid = v1; Req1Addr = a1; Req1Data = d1;
        ResvValid = rv; ResvAddr = ra;
        ChkAddrA = ca;  ChkAddrB = cb;
        #1;
        w = -1;
        if (v0 && v1)  w = (last_winner == 0) ? 1 : 0;
        else if (v0)   w = 0;
        else if (v1)   w = 1;
        chk("req0_ready", 32'(Req0Ready), 32'(w == 0));
        chk("req1_ready", 32'(Req1Ready), 32'(w == 1));
        chk("busy_a", 32'(ChkBusyA), 32'(ref_busy[ca]));
        chk("busy_b", 32'(ChkBusyB), 32'(ref_busy[cb]));
        ga = (w == 0) ? a0 : a1;
        if (w >= 0) begin
            e.cyc  = cyc + 1;
            e.addr = ga;
            e.data = (w == 0) ? d0 : d1;
            exp_q.push_back(e);
            last_winner = w;
        end
        if (ret_v) ref_busy[ret_a] = 1'b0;
        if (rv && ra != '0) ref_busy[ra] = 1'b1;
        ret_v = (w >= 0) && (ga != '0);
        ret_a = ga;
        g0_o  = (w == 0);
        g1_o  = (w == 1);
    endtask

    task automatic idle(input logic [AW-1:0] ca, input logic [AW-1:0] cb);
        drive_cycle(0, '0, '0, 0, '0, '0, 0, '0, ca, cb);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Reset = 1'b1;
            Req0Valid = 1'b1; Req1Valid = 1'b1;
            ResvValid = 1'b1; ResvAddr = AW'(i + 3);
            #1;
            chk("rst_req0_ready", 32'(Req0Ready), 32'd0);
            chk("rst_req1_ready", 32'(Req1Ready), 32'd0);
        end
        model_reset();
    endtask

    // Monitor: pops an expectation whenever one is due, otherwise demands idle/hold.
    initial begin
        logic [AW-1:0] h_a;
        logic [DW-1:0] h_d;
        exp_t          e;
        h_a = '0;
        h_d = '0;
        forever begin
            @(posedge Clk);
            #1;
            if (Reset) begin
                h_a = '0;
                h_d = '0;
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("regwrite", 32'(RegWrite), 32'(e.addr != '0));
                chk("wr_addr", 32'(RegWrAddr), 32'(e.addr));
                chk("wr_data", RegWrData, e.data);
                h_a = e.addr;
                h_d = e.data;
            end else begin
                chk("regwrite_idle", 32'(RegWrite), 32'd0);
                chk("hold_addr", 32'(RegWrAddr), 32'(h_a));
                chk("hold_data", RegWrData, h_d);
            end
        end
    end

    initial begin
        bit            p0v, p1v, rv;
        logic [AW-1:0] p0a, p1a, ra, ca, cb;
        logic [DW-1:0] p0d, p1d;

        Req0Valid = 0; Req1Valid = 0; ResvValid = 0;
        Req0Addr = '0; Req1Addr = '0; ResvAddr = '0; ChkAddrA = '0; ChkAddrB = '0;
        Req0Data = '0; Req1Data = '0;
        model_reset();
        do_reset(2);

        // Every busy bit reads 0 after reset and nothing is granted while idle.
        for (int i = 0; i < int'(NR / 2); i++) idle(AW'(2 * i), AW'(2 * i + 1));

        // Contention right after reset: requester 0 first, then strict alternation.
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1, AW'(1), 32'hA1A1_0001, 1, AW'(2), 32'hB2B2_0002, 0, '0, AW'(1), AW'(2));
            chk("contention_gnt0", 32'(g0_o), 32'(i % 2 == 0));
        end

        drive_cycle(1, AW'(5), 32'hDEAD_BEEF, 0, '0, '0, 0, '0, AW'(5), '0);
        idle(AW'(5), '0);
        idle(AW'(5), '0);

        // Reserve 7, write it back three cycles later via requester 1.
        drive_cycle(0, '0, '0, 0, '0, '0, 1, AW'(7), AW'(7), AW'(7));
        idle(AW'(7), '0);
        idle(AW'(7), '0);
        drive_cycle(0, '0, '0, 1, AW'(7), 32'h0000_7777, 0, '0, AW'(7), '0);
        idle(AW'(7), '0);
        chk("sb_busy_m4", 32'(ChkBusyA), 32'd1);
        idle(AW'(7), '0);
        chk("sb_clear_m5", 32'(ChkBusyA), 32'd0);

        // Re-reservation of 9 in the cycle its write commits keeps it busy.
        drive_cycle(0, '0, '0, 0, '0, '0, 1, AW'(9), AW'(9), '0);
        drive_cycle(1, AW'(9), 32'h9999_0001, 0, '0, '0, 0, '0, AW'(9), '0);
        drive_cycle(0, '0, '0, 0, '0, '0, 1, AW'(9), AW'(9), AW'(9));
        idle(AW'(9), '0);
        chk("collision_busy", 32'(ChkBusyA), 32'd1);
        drive_cycle(1, AW'(9), 32'h9999_0002, 0, '0, '0, 0, '0, AW'(9), '0);
        idle(AW'(9), '0);
        idle(AW'(9), '0);
        chk("collision_clear", 32'(ChkBusyA), 32'd0);

        // Register 0: reservation ignored, write accepted but suppressed.
        drive_cycle(1, '0, 32'h1234_5678, 0, '0, '0, 1, '0, '0, '0);
        idle('0, '0);
        idle('0, '0);

        // Reset mid-operation with reservations outstanding.
        drive_cycle(0, '0, '0, 0, '0, '0, 1, AW'(3), AW'(3), '0);
        drive_cycle(1, AW'(6), 32'h6666_6666, 1, AW'(4), 32'h4444_4444, 1, AW'(4), AW'(3), AW'(4));
        do_reset(1);
        idle(AW'(3), AW'(4));
        idle(AW'(5), AW'(6));
        drive_cycle(1, AW'(1), 32'h1, 1, AW'(2), 32'h2, 0, '0, '0, '0);
        chk("post_reset_gnt0", 32'(g0_o), 32'd1);

        // Random traffic with hold-stable requesters and legal reservations.
        p0v = 0; p1v = 0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!p0v && $urandom_range(0, 99) < 60) begin
                p0v = 1; p0a = AW'($urandom); p0d = $urandom;
            end
            if (!p1v && $urandom_range(0, 99) < 60) begin
                p1v = 1; p1a = AW'($urandom); p1d = $urandom;
            end
            ra = AW'($urandom);
            rv = ($urandom_range(0, 3) == 0);
            if (rv && ref_busy[ra] && !(ret_v && ret_a == ra)) rv = 0;
            ca = AW'($urandom);
            cb = rv ? ra : AW'($urandom);
            drive_cycle(p0v, p0a, p0d, p1v, p1a, p1d, rv, ra, ca, cb);
            if (g0_o) p0v = 0;
            if (g1_o) p1v = 0;
        end

        idle('0, '0);
        idle('0, '0);
        idle('0, '0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
